b_mem_sched: RTL
================

Name: b_mem_sched

Overview:
Burst scheduler for the layered partial-sum (beta) register store of the SCAN polar decoder.
- Two requesters are served: the beta-update engine (write) and the f/g node unit (read).
- Each accepted request is expanded into a burst that drives the store's layer select, beat count and enable inputs.
- Enforces read-after-write ordering on the same layer and returns read data beats aligned to the store's 1-cycle read latency.

Parameters:
N, 1024, code length
P, 32, LLRs per read beat (write beat carries 2*P)
LMAX, 8, highest stored layer (log2(N)-2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_req  in  1  write burst request (level)
wr_layer  in  5  target layer of write request
wr_gnt  out  1  pulse on first write beat
wr_beat  out  5  current write beat index (writer presents b_in for this beat)
wr_last  out  1  final write beat
wr_done  out  1  pulse, cycle after last write beat
rd_req  in  1  read burst request (level)
rd_layer  in  5  target layer of read request
rd_gnt  out  1  pulse on first read-enable beat
rd_valid  out  1  store output valid this cycle
rd_beat  out  5  beat index of valid read data
rd_last  out  1  final valid read beat
layer_w  out  5  to store write layer
cnta  out  5  to store write count
w_en  out  1  to store write enable
layer_r  out  5  to store read layer
cntb  out  5  to store read count
r_en  out  1  to store read enable
busy  out  1  either FSM not IDLE
err  out  1  pulse: illegal layer requested

Behaviour:
- Reset: all outputs 0; both FSMs go to IDLE. Reset mid-burst abandons the burst: no done/last/valid pulse is issued.
- Burst lengths (layer entries = 2^layer):
  - write beats WB = max(1, 2^layer/(2P)): layer 8 → 4, 7 → 2, ≤6 → 1
  - read beats RB = max(1, 2^layer/P): 8 → 8, 7 → 4, 6 → 2, ≤5 → 1
- Write FSM: IDLE → BURST → DONE → IDLE.
  - IDLE samples wr_req at cycle T, latches wr_layer into layer_w.
  - BURST runs T+1 .. T+WB: w_en=1, cnta=wr_beat=0..WB-1, wr_gnt=1 on beat 0, wr_last=1 on beat WB-1.
  - DONE (one cycle): w_en=0, wr_done=1.
  - A request still high in the next IDLE starts a new burst, so there is a minimum 2-cycle w_en gap between bursts.
- Read FSM: IDLE → BURST → IDLE.
  - IDLE samples rd_req at cycle T, latches layer_r.
  - BURST runs T+1 .. T+RB: r_en=1, cntb=0..RB-1, rd_gnt on beat 0.
  - rd_valid, rd_beat and rd_last are r_en, cntb and (last beat) delayed by one register, matching the store's registered output.
- Hazard: read acceptance in IDLE is blocked (read FSM stays IDLE, request held) when either condition holds:
  - the write FSM is in BURST with layer_w == rd_layer, or
  - the write FSM accepts a request with wr_layer == rd_layer in the same cycle.
  Write wins simultaneous same-layer requests. A read may be accepted in the write DONE cycle. Reads and writes to different layers overlap freely.
- Illegal layer (0 or > LMAX):
  - the request is consumed with err=1 for one cycle and no enable asserted;
  - write FSM passes through DONE, so wr_done pulses the next cycle;
  - read FSM returns to IDLE without rd_valid.
- Counters are 5 bits; beat index never exceeds 7 and never wraps.
- Outputs to the store are registered; no combinational path from req to enables.

Decomposition:
Shared package b_mem_pkg holds:
- constants N, P, LMAX
- functions wr_beats(layer) and rd_beats(layer)
- the FSM state enum

One sub-module, b_burst_ctr: a generic IDLE/BURST counter with start, length, beat, last and done outputs. It is instantiated twice (write and read). The top level adds the DONE state, hazard logic and read-latency alignment.

Test Plan:
1. wr_req, layer 8 at T → w_en high T+1..T+4, cnta 0,1,2,3, wr_gnt at T+1, wr_last at T+4, wr_done at T+5, w_en low T+5.
2. rd_req, layer 6 at T → r_en T+1..T+2 with cntb 0,1; rd_valid T+2..T+3, rd_beat 0,1, rd_last at T+3.
3. wr layer 7 accepted at T; rd layer 7 raised at T+1 → r_en stays low until DONE at T+3, read sampled T+3, first r_en T+4.
4. wr layer 8 and rd layer 5 both at T → w_en T+1..T+4 and r_en at T+1 overlap; same case with rd layer 8 → r_en first at T+6.
5. wr_req layer 9 → err at T+1, w_en never high, wr_done at T+2; rd_req layer 0 → err, no rd_valid.
6. rd layer 8 burst, rst asserted at beat 3 → following cycle r_en=0, rd_valid=0, busy=0, no rd_last ever; new request after rst works normally.

Source files
------------

// File: rtl/b_mem_pkg.sv
// Shared constants, burst-length helpers and FSM state encoding for the
// beta-store burst scheduler.
package b_mem_pkg;

    localparam int unsigned N        = 1024;
    localparam int unsigned P        = 32;
    localparam int unsigned LMAX     = $clog2(N) - 2;
    localparam int unsigned LW       = 5;
    localparam int unsigned WB_SHIFT = $clog2(2 * P);
    localparam int unsigned RB_SHIFT = $clog2(P);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Write beats carry 2*P entries: max(1, 2^layer / 2P)
    function automatic logic [LW-1:0] wr_beats(input logic [LW-1:0] layer);
        if (32'(layer) > WB_SHIFT)
            return LW'(1) << (32'(layer) - WB_SHIFT);
        return LW'(1);
    endfunction

    // Read beats carry P entries: max(1, 2^layer / P)
    function automatic logic [LW-1:0] rd_beats(input logic [LW-1:0] layer);
        if (32'(layer) > RB_SHIFT)
            return LW'(1) << (32'(layer) - RB_SHIFT);
        return LW'(1);
    endfunction

    function automatic logic layer_ok(input logic [LW-1:0] layer);
        return (layer != '0) && (32'(layer) <= LMAX);
    endfunction

endpackage

// File: rtl/b_burst_ctr.sv
// Generic IDLE/BURST beat counter: on start, runs len beats with registered
// active/first/beat/last; done_c flags the final beat for the parent FSM.
module b_burst_ctr
    import b_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          active,
    output logic          first,
    output logic [LW-1:0] beat,
    output logic          last,
    output logic          done_c
);

    state_t        state, state_d;
    logic          active_d, first_d, last_d;
    logic [LW-1:0] beat_d, len_q, len_d;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        active_d = active;
        first_d  = 1'b0;
        beat_d   = beat;
        last_d   = last;
        len_d    = len_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BURST;
                    active_d = 1'b1;
                    first_d  = 1'b1;
                    beat_d   = '0;
                    last_d   = (len <= LW'(1));
                    len_d    = len;
                end
            end
            S_BURST: begin
                if (last) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                    beat_d   = '0;
                    last_d   = 1'b0;
                end else begin
                    beat_d = LW'(beat + LW'(1));
                    last_d = (LW'(beat + LW'(2)) == len_q);
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
                beat_d   = '0;
                last_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            first  <= 1'b0;
            beat   <= '0;
            last   <= 1'b0;
            len_q  <= '0;
        end else begin
            active <= active_d;
            first  <= first_d;
            beat   <= beat_d;
            last   <= last_d;
            len_q  <= len_d;
        end
    end

    assign done_c = (state == S_BURST) && last;

endmodule

// File: rtl/b_mem_sched.sv
// Burst scheduler for the SCAN beta store: write/read FSMs, read-after-write
// layer hazard, and 1-cycle read-data alignment.
module b_mem_sched
    import b_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [LW-1:0] wr_layer,
    output logic          wr_gnt,
    output logic [LW-1:0] wr_beat,
    output logic          wr_last,
    output logic          wr_done,
    input  logic          rd_req,
    input  logic [LW-1:0] rd_layer,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [LW-1:0] rd_beat,
    output logic          rd_last,
    output logic [LW-1:0] layer_w,
    output logic [LW-1:0] cnta,
    output logic          w_en,
    output logic [LW-1:0] layer_r,
    output logic [LW-1:0] cntb,
    output logic          r_en,
    output logic          busy,
    output logic          err
);

    state_t wr_state, wr_next, rd_state, rd_next;
    logic   wr_start, wr_bad, rd_start, rd_bad, rd_block;
    logic   wr_fin_c, rd_fin_c, rd_end;

    b_burst_ctr u_wr_ctr (
        .clk    (clk),
        .rst    (rst),
        .start  (wr_start),
        .len    (wr_beats(wr_layer)),
        .active (w_en),
        .first  (wr_gnt),
        .beat   (cnta),
        .last   (wr_last),
        .done_c (wr_fin_c)
    );

    b_burst_ctr u_rd_ctr (
        .clk    (clk),
        .rst    (rst),
        .start  (rd_start),
        .len    (rd_beats(rd_layer)),
        .active (r_en),
        .first  (rd_gnt),
        .beat   (cntb),
        .last   (rd_end),
        .done_c (rd_fin_c)
    );

    assign wr_beat = cnta;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= S_IDLE;
            rd_state <= S_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Write FSM: illegal layers still pass through DONE so wr_done always pulses
    always_comb begin
        wr_next  = wr_state;
        wr_start = 1'b0;
        wr_bad   = 1'b0;
        case (wr_state)
            S_IDLE: begin
                if (wr_req) begin
                    if (layer_ok(wr_layer)) begin
                        wr_next  = S_BURST;
                        wr_start = 1'b1;
                    end else begin
                        wr_next = S_ERR;
                        wr_bad  = 1'b1;
                    end
                end
            end
            S_BURST: if (wr_fin_c) wr_next = S_DONE;
            S_ERR:   wr_next = S_DONE;
            default: wr_next = S_IDLE;
        endcase
    end

    // Read FSM: held off while a same-layer write is bursting or being accepted
    always_comb begin
        rd_next  = rd_state;
        rd_start = 1'b0;
        rd_bad   = 1'b0;
        rd_block = ((wr_state == S_BURST) && (layer_w == rd_layer)) ||
                   (wr_start && (wr_layer == rd_layer));
        case (rd_state)
            S_IDLE: begin
                if (rd_req && !rd_block) begin
                    if (layer_ok(rd_layer)) begin
                        rd_next  = S_BURST;
                        rd_start = 1'b1;
                    end else begin
                        rd_next = S_ERR;
                        rd_bad  = 1'b1;
                    end
                end
            end
            S_BURST: if (rd_fin_c) rd_next = S_IDLE;
            default: rd_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_w  <= '0;
            layer_r  <= '0;
            wr_done  <= 1'b0;
            rd_valid <= 1'b0;
            rd_beat  <= '0;
            rd_last  <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (wr_state == S_IDLE && wr_req) layer_w <= wr_layer;
            if (rd_start || rd_bad)           layer_r <= rd_layer;
            wr_done  <= (wr_next == S_DONE);
            rd_valid <= r_en;
            rd_beat  <= cntb;
            rd_last  <= rd_end;
            err      <= wr_bad || rd_bad;
            busy     <= (wr_next != S_IDLE) || (rd_next != S_IDLE);
        end
    end

endmodule
